// File: rtl/agu_nd.sv
// agu_nd: N-loop nested address generator with latched config.
// Optional AGU_ONESHOT_EN: stop in IDLE after one full pass of the nest.
module agu_nd #(
   parameter int BWADDR   = 21,
   parameter int BWLENGTH = 8,
   parameter int NLOOPS   = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         step,
   input  logic [BWADDR-1:0]            base,
   input  logic [NLOOPS*BWLENGTH-1:0]   lengths,
   input  logic [(NLOOPS+1)*BWADDR-1:0] jumps,
   output logic [BWADDR-1:0]            addr_out,
   output logic                         busy,
   output logic [NLOOPS-1:0]            z_out,
   output logic                         done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              r_state, w_state_nx;
   logic [BWADDR-1:0]   r_addr, w_addr_nx, w_jmp;
   logic [BWLENGTH-1:0] r_cnt [NLOOPS];
   logic [BWLENGTH-1:0] w_cnt_nx [NLOOPS];
   logic [BWLENGTH-1:0] w_cnt_step [NLOOPS];
   logic [BWLENGTH-1:0] r_len [NLOOPS];
   logic [BWLENGTH-1:0] w_len_nx [NLOOPS];
   logic [BWADDR-1:0]   r_jmp [NLOOPS+1];
   logic [BWADDR-1:0]   w_jmp_nx [NLOOPS+1];
   logic                r_done, w_done_nx, w_found;

   // Lowest non-zero counter decrements; all loops below it reload.
   always_comb begin
      w_found = 1'b0;
      w_jmp   = r_jmp[NLOOPS];
      for (int k = 0; k < NLOOPS; k++) begin
         w_cnt_step[k] = r_cnt[k];
         if (!w_found) begin
            if (r_cnt[k] != '0) begin
               w_found       = 1'b1;
               w_jmp         = r_jmp[k];
               w_cnt_step[k] = r_cnt[k] - BWLENGTH'(1);
            end else begin
               w_cnt_step[k] = r_len[k];
            end
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_cnt_nx   = r_cnt;
      w_len_nx   = r_len;
      w_jmp_nx   = r_jmp;
      w_done_nx  = 1'b0;
      if (abort) begin
         w_state_nx = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int k = 0; k < NLOOPS; k++) begin
                     w_len_nx[k] = lengths[k*BWLENGTH +: BWLENGTH];
                     w_cnt_nx[k] = lengths[k*BWLENGTH +: BWLENGTH];
                  end
                  for (int k = 0; k <= NLOOPS; k++)
                     w_jmp_nx[k] = jumps[k*BWADDR +: BWADDR];
                  w_addr_nx  = base;
                  w_state_nx = S_RUN;
               end
            end
            S_RUN: begin
               if (step) begin
                  if (!w_found) begin
`ifdef AGU_ONESHOT_EN
                     w_state_nx = S_IDLE;
                     w_done_nx  = 1'b1;
`else
                     w_addr_nx  = r_addr + w_jmp;
                     w_cnt_nx   = w_cnt_step;
                     w_done_nx  = 1'b1;
`endif
                  end else begin
                     w_addr_nx = r_addr + w_jmp;
                     w_cnt_nx  = w_cnt_step;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_done  <= 1'b0;
         for (int k = 0; k < NLOOPS; k++) begin
            r_cnt[k] <= '0;
            r_len[k] <= '0;
         end
         for (int k = 0; k <= NLOOPS; k++)
            r_jmp[k] <= '0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_done  <= w_done_nx;
         r_cnt   <= w_cnt_nx;
         r_len   <= w_len_nx;
         r_jmp   <= w_jmp_nx;
      end
   end

   assign addr_out = r_addr;
   assign busy     = (r_state == S_RUN);
   assign done     = r_done;

   always_comb begin
      for (int k = 0; k < NLOOPS; k++)
         z_out[k] = step & busy & (r_cnt[k] == '0);
   end

endmodule

// File: tb/tb_agu_nd.sv
// tb_agu_nd: directed scoreboard bench for agu_nd.
// Driver queues per-cycle expectations; monitor checks them at negedge.
module tb_agu_nd;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          step = 1'b0;
   logic [20:0]   base = '0;
   logic [23:0]   lengths = '0;
   logic [83:0]   jumps = '0;
   logic [20:0]   addr_out;
   logic          busy;
   logic [2:0]    z_out;
   logic          done;

`ifdef AGU_ONESHOT_EN
   localparam bit OS = 1'b1;
`else
   localparam bit OS = 1'b0;
`endif

   typedef struct packed {
      logic [20:0] a;
      logic        b;
      logic        d;
      logic [2:0]  z;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   int    n_chk = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   agu_nd dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .step     (step),
      .base     (base),
      .lengths  (lengths),
      .jumps    (jumps),
      .addr_out (addr_out),
      .busy     (busy),
      .z_out    (z_out),
      .done     (done)
   );

   task automatic chk(input string nm, input string f,
                      input logic [20:0] act, input logic [20:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            chk(nm, "addr", addr_out, e.a);
            chk(nm, "busy", 21'(busy), 21'(e.b));
            chk(nm, "done", 21'(done), 21'(e.d));
            chk(nm, "z", 21'(z_out), 21'(e.z));
         end
      end
   end

   task automatic cyc(input logic rn, st, sp, ab,
                      input logic [20:0] ea, input logic eb, ed,
                      input logic [2:0] ez, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rn;
      start = st;
      step  = sp;
      abort = ab;
      e = '{a: ea, b: eb, d: ed, z: ez};
      q.push_back(e);
      nq.push_back(nm);
   endtask

   task automatic cfg_basic();
      base    = 21'd5;
      lengths = {8'd0, 8'd1, 8'd1};
      jumps   = {21'd1000, 21'd100, 21'd10, 21'd1};
   endtask

   initial begin
      cfg_basic();
      cyc(0, 0, 0, 0, 21'd0, 0, 0, 3'b000, "rst");
      cyc(1, 0, 1, 0, 21'd0, 0, 0, 3'b000, "idle_step");
      cyc(1, 1, 1, 0, 21'd0, 0, 0, 3'b000, "start");
      cyc(1, 0, 1, 0, 21'd5, 1, 0, 3'b100, "s1");
      cyc(1, 0, 1, 0, 21'd6, 1, 0, 3'b101, "s2");
      cyc(1, 0, 1, 0, 21'd16, 1, 0, 3'b110, "s3");
      cyc(1, 0, 1, 0, 21'd17, 1, 0, 3'b111, "s4_end");
      cyc(1, 0, 0, 0, OS ? 21'd17 : 21'd1017, !OS, 1, 3'b000, "done");
      cyc(1, 0, 1, 0, OS ? 21'd17 : 21'd1017, !OS, 0,
          OS ? 3'b000 : 3'b100, "post");
      cyc(1, 0, 0, 1, OS ? 21'd17 : 21'd1018, !OS, 0, 3'b000, "abort0");
      cyc(1, 0, 0, 0, OS ? 21'd17 : 21'd1018, 0, 0, 3'b000, "idle0");
      cyc(1, 1, 0, 0, OS ? 21'd17 : 21'd1018, 0, 0, 3'b000, "startB");
      cyc(1, 0, 1, 0, 21'd5, 1, 0, 3'b100, "b1");
      base    = '0;
      lengths = '0;
      jumps   = '0;
      cyc(1, 1, 1, 0, 21'd6, 1, 0, 3'b101, "b2_start");
      cyc(1, 0, 0, 1, 21'd16, 1, 0, 3'b000, "b_abort");
      cyc(1, 0, 1, 0, 21'd16, 0, 0, 3'b000, "ab_step");
      cfg_basic();
      cyc(1, 1, 0, 0, 21'd16, 0, 0, 3'b000, "ab_hold");
      cyc(1, 0, 0, 0, 21'd5, 1, 0, 3'b000, "restart");
      cyc(1, 0, 0, 1, 21'd5, 1, 0, 3'b000, "abortC");
      base    = '0;
      lengths = {8'd0, 8'd0, 8'd3};
      jumps   = {21'd0, 21'd0, 21'd0, 21'h1FFFFF};
      cyc(1, 1, 0, 0, 21'd5, 0, 0, 3'b000, "startC");
      cyc(1, 0, 1, 0, 21'd0, 1, 0, 3'b110, "w1");
      cyc(1, 0, 1, 0, 21'h1FFFFF, 1, 0, 3'b110, "wrap");
      cyc(1, 0, 0, 0, 21'h1FFFFE, 1, 0, 3'b000, "wrap2");
      cyc(0, 0, 1, 0, 21'd0, 0, 0, 3'b000, "arst");
      cyc(1, 0, 1, 0, 21'd0, 0, 0, 3'b000, "rel_step");
      cyc(1, 0, 1, 0, 21'd0, 0, 0, 3'b000, "rel_step2");
      cyc(1, 1, 0, 0, 21'd0, 0, 0, 3'b000, "startD");
      cyc(1, 0, 0, 0, 21'd0, 1, 0, 3'b000, "runD");
      for (int t = 0; t < 10 && q.size() != 0; t++)
         @(posedge clk);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
